pc_fetch_unit: RTL

Instruction-fetch front end that owns the program counter. Sends word fetches to instruction memory over a req/ack handshake and fills the IF/ID register with Instr and IncPC. IncPC is the value the next-PC/branch logic consumes. The block accepts that logic's PCScr/AddrNextPC redirect and the decode-stage Stall, and handles flush and discard of wrong-path fetches. At most one memory request is outstanding.

---
 rtl/mips_pkg.sv | 12 +
 rtl/fetch_skid_buffer.sv | 50 +++++
 rtl/pc_fetch_unit.sv | 137 +++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared word width, fetch defaults and fetch state encoding
package mips_pkg;
  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
  localparam logic [WORD_W-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;
endpackage

// File: rtl/fetch_skid_buffer.sv
// rtl/fetch_skid_buffer.sv - one-entry Instr/IncPC holding slot for a stalled fetch
module fetch_skid_buffer
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              unload,
  input  logic              flush,
  input  logic [WORD_W-1:0] load_instr,
  input  logic [WORD_W-1:0] load_inc_pc,
  output logic              full,
  output logic [WORD_W-1:0] instr,
  output logic [WORD_W-1:0] inc_pc
);
  logic              full_q, full_d;
  logic [WORD_W-1:0] instr_q, instr_d;
  logic [WORD_W-1:0] inc_pc_q, inc_pc_d;

  always_comb begin
    full_d   = full_q;
    instr_d  = instr_q;
    inc_pc_d = inc_pc_q;
    if (flush) begin
      full_d = 1'b0;
    end else if (load) begin
      full_d   = 1'b1;
      instr_d  = load_instr;
      inc_pc_d = load_inc_pc;
    end else if (unload) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      full_q   <= 1'b0;
      instr_q  <= '0;
      inc_pc_q <= '0;
    end else begin
      full_q   <= full_d;
      instr_q  <= instr_d;
      inc_pc_q <= inc_pc_d;
    end
  end

  assign full   = full_q;
  assign instr  = instr_q;
  assign inc_pc = inc_pc_q;
endmodule

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - PC owner issuing one-at-a-time word fetches into the IF/ID register
module pc_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [WORD_W-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              PCScr,
  input  logic [WORD_W-1:0] AddrNextPC,
  input  logic              Stall,
  output logic              IMemReq,
  output logic [WORD_W-1:0] IMemAddr,
  input  logic              IMemAck,
  input  logic [WORD_W-1:0] IMemRData,
  output logic [WORD_W-1:0] Instr,
  output logic [WORD_W-1:0] IncPC,
  output logic              InstrValid,
  output logic [WORD_W-1:0] PC
);
  localparam logic [WORD_W-1:0] ALIGN_MASK = ~32'd3;

  fetch_state_e      state_q, state_d;
  logic [WORD_W-1:0] pc_q, pc_d;
  logic [WORD_W-1:0] addr_q, addr_d;
  logic              drop_q, drop_d;
  logic [WORD_W-1:0] instr_q, instr_d;
  logic [WORD_W-1:0] inc_pc_q, inc_pc_d;
  logic              valid_q, valid_d;

  logic              req, ack;
  logic [WORD_W-1:0] pc_plus4;
  logic              skid_load, skid_unload, skid_flush, skid_full;
  logic [WORD_W-1:0] skid_instr, skid_inc_pc;

  assign req      = (state_q == REQ);
  assign ack      = req & IMemAck;
  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_d      = drop_q;
    instr_d     = instr_q;
    inc_pc_d    = inc_pc_q;
    valid_d     = Stall ? valid_q : 1'b0;
    skid_load   = 1'b0;
    skid_unload = 1'b0;
    skid_flush  = 1'b0;

    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (ack) begin
          if (drop_q) begin
            drop_d = 1'b0;
          end else if (!valid_q || !Stall) begin
            instr_d  = IMemRData;
            inc_pc_d = pc_plus4;
            valid_d  = 1'b1;
            pc_d     = pc_plus4;
          end else begin
            skid_load = 1'b1;
            pc_d      = pc_plus4;
            state_d   = HOLD;
          end
        end
      end
      HOLD: begin
        if (!Stall) begin
          instr_d     = skid_instr;
          inc_pc_d    = skid_inc_pc;
          valid_d     = 1'b1;
          skid_unload = 1'b1;
          state_d     = REQ;
        end
      end
      default: state_d = IDLE;
    endcase

    // Redirect wins over stall; an unacked request must finish at its old address, so mark it for discard.
    if (PCScr) begin
      pc_d        = AddrNextPC & ALIGN_MASK;
      valid_d     = 1'b0;
      instr_d     = instr_q;
      inc_pc_d    = inc_pc_q;
      skid_load   = 1'b0;
      skid_unload = 1'b0;
      skid_flush  = 1'b1;
      state_d     = REQ;
      if (req && !IMemAck) drop_d = 1'b1;
    end

    addr_d = (req && !IMemAck) ? addr_q : pc_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC & ALIGN_MASK;
      addr_q   <= RESET_PC & ALIGN_MASK;
      drop_q   <= 1'b0;
      instr_q  <= NOP_INSTR;
      inc_pc_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      drop_q   <= drop_d;
      instr_q  <= instr_d;
      inc_pc_q <= inc_pc_d;
      valid_q  <= valid_d;
    end
  end

  fetch_skid_buffer u_skid (
    .clk         (clk),
    .reset       (reset),
    .load        (skid_load),
    .unload      (skid_unload),
    .flush       (skid_flush),
    .load_instr  (IMemRData),
    .load_inc_pc (pc_plus4),
    .full        (skid_full),
    .instr       (skid_instr),
    .inc_pc      (skid_inc_pc)
  );

  assign IMemReq    = req & ~skid_full;
  assign IMemAddr   = addr_q;
  assign Instr      = instr_q;
  assign IncPC      = inc_pc_q;
  assign InstrValid = valid_q;
  assign PC         = pc_q;
endmodule
